// File: rtl/apb_cmd_pkg.sv
// Shared types and constants for the APB command master and its timer register map.
package apb_cmd_pkg;

  localparam int unsigned APB_ADDR_W_DEF = 12;
  localparam int unsigned APB_DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  // Timer block register offsets
  localparam logic [11:0] TCR   = 12'h000;
  localparam logic [11:0] TDR0  = 12'h004;
  localparam logic [11:0] TDR1  = 12'h008;
  localparam logic [11:0] TCMP0 = 12'h00C;
  localparam logic [11:0] TCMP1 = 12'h010;
  localparam logic [11:0] TIER  = 12'h014;
  localparam logic [11:0] TISR  = 12'h018;
  localparam logic [11:0] THCSR = 12'h01C;

endpackage

// File: rtl/apb_timeout_cnt.sv
// Counts ACCESS cycles while run is high; expired flags the TIMEOUT_CYC-th cycle.
// Zero latency on expired (combinational compare of the registered count); no backpressure.
module apb_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic run,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;

  // Held at zero outside ACCESS, so every ACCESS entry starts a fresh count
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
    end else if (!run) begin
      cnt_q <= '0;
    end else if (cnt_q != LAST) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = run && (cnt_q == LAST);

endmodule

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB master, registered outputs; response at accept+3 plus wait states.
// cmd_ready only in IDLE (no queuing); APB_TIMEOUT_EN adds an ACCESS-phase abort counter.
module apb_cmd_master
  import apb_cmd_pkg::*;
#(
  parameter int unsigned ADDR_W      = APB_ADDR_W_DEF,
  parameter int unsigned DATA_W      = APB_DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              tim_psel,
  output logic              tim_penable,
  output logic              tim_pwrite,
  output logic [ADDR_W-1:0] tim_paddr,
  output logic [DATA_W-1:0] tim_pwdata,
  input  logic [DATA_W-1:0] tim_prdata,
  input  logic              tim_pready,
  input  logic              tim_pslverr
);

  apb_state_e        state_q;
  apb_state_e        state_d;
  logic              req_write_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [DATA_W-1:0] req_wdata_q;

  logic              accept;
  logic              timeout_hit;
  logic              cur_write;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;

  logic              cmd_ready_d;
  logic              rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_d;
  logic              rsp_err_d;
  logic              rsp_timeout_d;
  logic              psel_d;
  logic              penable_d;
  logic              pwrite_d;
  logic [ADDR_W-1:0] paddr_d;
  logic [DATA_W-1:0] pwdata_d;

  assign accept = (state_q == ST_IDLE) && cmd_valid && cmd_ready;

  // Bus outputs are registered from next state, so SETUP must see the command being accepted
  assign cur_write = accept ? cmd_write : req_write_q;
  assign cur_addr  = accept ? cmd_addr  : req_addr_q;
  assign cur_wdata = accept ? cmd_wdata : req_wdata_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_write_q <= cmd_write;
        req_addr_q  <= cmd_addr;
        req_wdata_q <= cmd_wdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (tim_pready || timeout_hit) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_d   = (state_d == ST_IDLE);
    psel_d        = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    penable_d     = (state_d == ST_ACCESS);
    pwrite_d      = psel_d && cur_write;
    paddr_d       = psel_d   ? cur_addr  : '0;
    pwdata_d      = pwrite_d ? cur_wdata : '0;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = '0;
    rsp_err_d     = 1'b0;
    rsp_timeout_d = 1'b0;
    if ((state_q == ST_ACCESS) && (state_d == ST_RESP)) begin
      rsp_valid_d = 1'b1;
      // pready wins over a coincident timeout expiry
      if (tim_pready) begin
        rsp_err_d = tim_pslverr;
        if (!req_write_q && !tim_pslverr) rsp_rdata_d = tim_prdata;
      end else begin
        rsp_err_d     = 1'b1;
        rsp_timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      tim_psel    <= 1'b0;
      tim_penable <= 1'b0;
      tim_pwrite  <= 1'b0;
      tim_paddr   <= '0;
      tim_pwdata  <= '0;
    end else begin
      cmd_ready   <= cmd_ready_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_err     <= rsp_err_d;
      rsp_timeout <= rsp_timeout_d;
      tim_psel    <= psel_d;
      tim_penable <= penable_d;
      tim_pwrite  <= pwrite_d;
      tim_paddr   <= paddr_d;
      tim_pwdata  <= pwdata_d;
    end
  end

`ifdef APB_TIMEOUT_EN
  apb_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout_cnt (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .run      (state_q == ST_ACCESS),
    .expired  (timeout_hit)
  );
`else
  // Without the counter ACCESS waits for pready forever and rsp_timeout never rises
  assign timeout_hit = 1'b0;
  if (TIMEOUT_CYC == 0) begin : g_timeout_param_unused
  end
`endif

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed + randomized bench for apb_cmd_master with a behavioural APB slave and register model.
module tb_apb_cmd_master;
  import apb_cmd_pkg::*;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int          TO = 255;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          tim_psel;
  logic          tim_penable;
  logic          tim_pwrite;
  logic [AW-1:0] tim_paddr;
  logic [DW-1:0] tim_pwdata;
  logic [DW-1:0] tim_prdata;
  logic          tim_pready;
  logic          tim_pslverr;

  always #5 sys_clk = ~sys_clk;

  apb_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .tim_psel(tim_psel), .tim_penable(tim_penable), .tim_pwrite(tim_pwrite),
    .tim_paddr(tim_paddr), .tim_pwdata(tim_pwdata), .tim_prdata(tim_prdata),
    .tim_pready(tim_pready), .tim_pslverr(tim_pslverr)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] slv_regs[8];  // contents of the behavioural slave
  logic [31:0] ref_regs[8];  // what the register file should hold after each command

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command, act as the APB slave, and return what the response looked like.
  task automatic run_cmd(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input int waits, input bit noise, input int budget,
                         output int lat, output logic [DW-1:0] rd, output bit err, output bit to);
    int cyc;
    int acc;
    bit done;
    logic [DW-1:0] exp_pwdata;
    lat = -1; rd = '0; err = 1'b0; to = 1'b0;
    exp_pwdata = wr ? wdata : '0;
    chk("cmd_ready_idle", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    @(posedge sys_clk); #1;
    cmd_valid = noise;
    if (noise) begin
      cmd_write = 1'($urandom); cmd_addr = AW'($urandom); cmd_wdata = $urandom;
    end
    cyc = 1; acc = 0; done = 1'b0;
    chk("setup_psel_penable", 64'({tim_psel, tim_penable}), 64'(2'b10));
    chk("setup_paddr", 64'(tim_paddr), 64'(addr));
    chk("setup_pwrite", 64'(tim_pwrite), 64'(wr));
    chk("setup_pwdata", 64'(tim_pwdata), 64'(exp_pwdata));
    while (!done && cyc < budget) begin
      if (tim_psel && tim_penable) begin
        chk("access_paddr", 64'(tim_paddr), 64'(addr));
        chk("access_pwdata", 64'(tim_pwdata), 64'(exp_pwdata));
        if (acc >= waits) begin
          tim_pready = 1'b1;
          if (tim_paddr >= 12'h020) begin
            tim_pslverr = 1'b1;
            tim_prdata  = $urandom;
          end else begin
            tim_pslverr = 1'b0;
            tim_prdata  = tim_pwrite ? $urandom : slv_regs[tim_paddr[4:2]];
            if (tim_pwrite) slv_regs[tim_paddr[4:2]] = tim_pwdata;
          end
        end else begin
          tim_pready  = 1'b0;
          tim_pslverr = 1'($urandom);
          tim_prdata  = $urandom;
        end
        acc++;
      end else begin
        tim_pready  = 1'($urandom);
        tim_pslverr = 1'($urandom);
        tim_prdata  = $urandom;
      end
      @(posedge sys_clk); #1;
      cyc++;
      if (rsp_valid) begin
        done = 1'b1; lat = cyc; rd = rsp_rdata; err = rsp_err; to = rsp_timeout;
        cmd_valid = 1'b0; tim_pready = 1'b0;
        chk("resp_psel_penable", 64'({tim_psel, tim_penable}), 64'(2'b00));
        chk("resp_bus_zero", 64'({tim_pwrite, tim_paddr}), 64'(0));
        chk("resp_pwdata_zero", 64'(tim_pwdata), 64'(0));
      end
    end
    cmd_valid = 1'b0;
    if (done) begin
      @(posedge sys_clk); #1;
      chk("rsp_one_cycle", 64'(rsp_valid), 64'(0));
      chk("cmd_ready_after_resp", 64'(cmd_ready), 64'(1));
    end
  endtask

  // Reference: an error comes from addresses past the register file; latency is 3 + wait states.
  task automatic xact(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                      input int waits, input bit noise);
    bit exp_err;
    logic [DW-1:0] exp_rd;
    int lat;
    logic [DW-1:0] rd;
    bit err, to;
    exp_err = (addr >= 12'h020);
    exp_rd  = (!wr && !exp_err) ? ref_regs[addr[4:2]] : '0;
    if (wr && !exp_err) ref_regs[addr[4:2]] = wdata;
    run_cmd(wr, addr, wdata, waits, noise, waits + 20, lat, rd, err, to);
    chk("rsp_latency", 64'(lat), 64'(3 + waits));
    chk("rsp_rdata", 64'(rd), 64'(exp_rd));
    chk("rsp_err", 64'(err), 64'(exp_err));
    chk("rsp_timeout", 64'(to), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel;
    int lat;
    logic [DW-1:0] rd;
    bit err, to;
    bit wr;
    bit rsp_seen;
    logic [AW-1:0] addr;

    for (int i = 0; i < 8; i++) begin
      slv_regs[i] = $urandom;
      ref_regs[i] = slv_regs[i];
    end
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    tim_prdata = '0; tim_pready = 1'b0; tim_pslverr = 1'b0;

    // Reset state
    sys_rst_n = 1'b0;
    #2;
    chk("reset_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("reset_rsp", 64'({rsp_valid, rsp_err, rsp_timeout}), 64'(0));
    chk("reset_rsp_rdata", 64'(rsp_rdata), 64'(0));
    chk("reset_apb_ctrl", 64'({tim_psel, tim_penable, tim_pwrite}), 64'(0));
    chk("reset_paddr", 64'(tim_paddr), 64'(0));
    chk("reset_pwdata", 64'(tim_pwdata), 64'(0));
    #10 sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
    chk("cmd_ready_after_release", 64'(cmd_ready), 64'(1));

    // Directed: write/readback TCR, wait-stated TDR0 read, slave error
    xact(1'b1, TCR, 32'h0000_0103, 0, 1'b0);
    chk("slave_tcr", 64'(slv_regs[0]), 64'(32'h0000_0103));
    xact(1'b0, TCR, 32'h0, 0, 1'b0);
    slv_regs[1] = 32'h1234_ABCD;
    ref_regs[1] = 32'h1234_ABCD;
    xact(1'b0, TDR0, 32'h0, 3, 1'b0);
    xact(1'b0, 12'h020, 32'h0, 0, 1'b0);
    xact(1'b1, 12'h024, 32'hDEAD_BEEF, 1, 1'b1);

    // Randomized traffic, with cmd_valid noise while busy
    for (int i = 0; i < 16; i++) begin
      sel  = $urandom_range(0, 9);
      addr = (sel < 8) ? AW'(sel * 4) : AW'(32 + (sel - 8) * 4);
      wr   = 1'($urandom_range(0, 1));
      xact(wr, addr, $urandom, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 8; i++) begin
      xact(1'b0, AW'(i * 4), 32'h0, $urandom_range(0, 2), 1'b0);
      chk("slave_matches_model", 64'(slv_regs[i]), 64'(ref_regs[i]));
    end

`ifdef APB_TIMEOUT_EN
    // pready never arrives: abort after TO ACCESS cycles
    run_cmd(1'b0, TDR1, 32'h0, 1 << 30, 1'b0, TO + 20, lat, rd, err, to);
    chk("timeout_latency", 64'(lat), 64'(2 + TO));
    chk("timeout_err", 64'({err, to}), 64'(2'b11));
    chk("timeout_rdata", 64'(rd), 64'(0));
    // pready on the expiring cycle completes normally
    xact(1'b0, TDR1, 32'h0, TO - 1, 1'b0);
`else
    run_cmd(1'b0, TDR1, 32'h0, 1 << 30, 1'b0, 1000, lat, rd, err, to);
    chk("no_timeout_no_rsp", 64'(lat), 64'(-1));
    chk("still_in_access", 64'({tim_psel, tim_penable}), 64'(2'b11));
    #2 sys_rst_n = 1'b0;
    @(posedge sys_clk); #2 sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
`endif

    // Reset pulse in the middle of ACCESS
    chk("idle_before_abort", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = TCMP0; cmd_wdata = '0;
    tim_pready = 1'b0;
    @(posedge sys_clk); #1;
    cmd_valid = 1'b0;
    @(posedge sys_clk); #1;
    chk("abort_in_access", 64'({tim_psel, tim_penable}), 64'(2'b11));
    #2 sys_rst_n = 1'b0;
    #1;
    chk("abort_psel_penable", 64'({tim_psel, tim_penable}), 64'(2'b00));
    chk("abort_no_rsp", 64'(rsp_valid), 64'(0));
    chk("abort_cmd_ready", 64'(cmd_ready), 64'(0));
    @(posedge sys_clk); #2 sys_rst_n = 1'b1;
    rsp_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge sys_clk); #1;
      rsp_seen = rsp_seen | rsp_valid;
    end
    chk("abort_no_rsp_after", 64'(rsp_seen), 64'(0));
    xact(1'b1, TIER, 32'h0000_0005, 2, 1'b0);
    xact(1'b0, TIER, 32'h0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
